// File: rtl/ula_pkg.sv
// ula_pkg - shared constants for the EX-stage ALU control / multiply-divide block.
//   OP_*      4-bit ULA operation codes
//   ALU_*     3-bit ALUOp classes from the main control unit
//   F_*       R-type funct values that need special handling
//   md_state_e  multiply/divide sequencer state encoding
//   HILO_*    hilo_rd codes (which of HI/LO the writeback mux selects)
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b1110;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b110;
  localparam logic [2:0] ALU_PASS  = 3'b111;

  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_LO   = 2'b01;
  localparam logic [1:0] HILO_HI   = 2'b10;

endpackage

// File: rtl/ula_md_iter.sv
// ula_md_iter - iterative radix-2 multiply / restoring-divide datapath.
//   Macro ULA_MD_DIV_EN: when defined the divide step, divide fix-up and the
//   is_div_i port exist; otherwise only the shift-add multiplier is built.
// Ports:
//   clk, reset          clock, async active-high reset
//   start_i             load operand magnitudes and sign flags, clear counter
//   busy_i              perform one iteration this cycle
//   is_div_i            (ULA_MD_DIV_EN only) operation is a divide
//   is_signed_i         operands are two's complement
//   a_i, b_i            rs (multiplicand / dividend), rt (multiplier / divisor)
//   last_o              the current iteration is the final one
//   hi_res_o, lo_res_o  sign-corrected result as it will be after this iteration
module ula_md_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             busy_i,
`ifdef ULA_MD_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_res_o,
  output logic [WIDTH-1:0] lo_res_o
);

  logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d, opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ULA_MD_DIV_EN
  logic               div_q, neg_r_q, bzero_q;
  logic [WIDTH-1:0]   araw_q;
  logic [WIDTH:0]     shl, diff;
`endif

  assign mag_a  = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b  = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign last_o = (cnt_q == CNT_W'(WIDTH-1));

  // Multiply: {acc,sh} shifts right, adding the multiplicand when sh[0] is set.
  // Divide: {acc,sh} shifts left, quotient bit enters at sh[0].
  always_comb begin
    sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    acc_d = sum[WIDTH:1];
    sh_d  = {sum[0], sh_q[WIDTH-1:1]};
`ifdef ULA_MD_DIV_EN
    shl  = {acc_q, sh_q[WIDTH-1]};
    diff = shl - {1'b0, opnd_q};
    if (div_q) begin
      acc_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  always_comb begin
    prod     = neg_q ? -{acc_d, sh_d} : {acc_d, sh_d};
    hi_res_o = prod[2*WIDTH-1:WIDTH];
    lo_res_o = prod[WIDTH-1:0];
`ifdef ULA_MD_DIV_EN
    if (div_q) begin
      // Divide by zero reports the raw dividend, not its magnitude.
      if (bzero_q) begin
        hi_res_o = araw_q;
        lo_res_o = '1;
      end else begin
        lo_res_o = neg_q ? -sh_d : sh_d;
        hi_res_o = neg_r_q ? -acc_d : acc_d;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
`ifdef ULA_MD_DIV_EN
      div_q   <= 1'b0;
      neg_r_q <= 1'b0;
      bzero_q <= 1'b0;
      araw_q  <= '0;
`endif
    end else if (start_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      sh_q   <= mag_b;
      opnd_q <= mag_a;
`ifdef ULA_MD_DIV_EN
      div_q   <= is_div_i;
      neg_r_q <= is_signed_i & a_i[WIDTH-1];
      bzero_q <= (b_i == '0);
      araw_q  <= a_i;
      if (is_div_i) begin
        sh_q   <= mag_a;
        opnd_q <= mag_b;
      end
`endif
    end else if (busy_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ula_ctrl_md.sv
// ula_ctrl_md - EX-stage ALU control with a sequential multiply/divide unit.
//   Macro ULA_MD_DIV_EN: defined -> div/divu execute; undefined -> they decode
//   as no-ops and the divide datapath is not built.
// Ports:
//   clk, reset        clock, async active-high reset
//   ex_en             EX instruction valid (gates MD start and hilo_rd)
//   ALUOp, funct      control class and R-type funct
//   rs_val, rt_val    MD operands
//   OP, Jr            combinational ULA decode
//   hilo_rd           00 none, 01 LO, 10 HI (mflo / mfhi)
//   md_stall          pipeline hold while an MD operation is starting/running
//   md_done           one-cycle pulse when HI/LO take the new result
//   hi, lo            HI/LO registers
//
// state  | meaning
// IDLE   | no operation; accepts a new MD op
// BUSY   | one radix-2 iteration per cycle, WIDTH cycles
// DONE   | HI/LO just written, md_done high; re-presented op ignored
module ula_ctrl_md
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_en,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       OP,
  output logic             Jr,
  output logic [1:0]       hilo_rd,
  output logic             md_stall,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_res, lo_res;
  logic             done_q, rtype, is_mul, is_dvd, start, last;

  assign rtype  = (ALUOp == ALU_RTYPE);
  assign is_mul = rtype && (funct == F_MULT || funct == F_MULTU);
`ifdef ULA_MD_DIV_EN
  assign is_dvd = rtype && (funct == F_DIV || funct == F_DIVU);
`else
  assign is_dvd = 1'b0;
`endif
  assign start  = !reset && ex_en && (is_mul || is_dvd) && (state_q == S_IDLE);

  // DONE releases the pipeline: HI/LO already hold the result, so a waiting
  // mfhi/mflo can proceed and the re-presented MD op retires.
  assign md_stall = start || (state_q == S_BUSY);
  assign md_done  = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign Jr       = rtype && (funct == F_JR);

  always_comb begin
    OP = OP_ADD;
    case (ALUOp)
      ALU_ADD:  OP = OP_ADD;
      ALU_SUB:  OP = OP_SUB;
      ALU_AND:  OP = OP_AND;
      ALU_OR:   OP = OP_OR;
      ALU_XOR:  OP = OP_XOR;
      ALU_SLT:  OP = OP_SLT;
      ALU_RTYPE: begin
        casez (funct)
          6'b10000?:           OP = OP_ADD;
          6'b10001?:           OP = OP_SUB;
          F_AND:               OP = OP_AND;
          F_OR:                OP = OP_OR;
          F_XOR:               OP = OP_XOR;
          F_NOR:               OP = OP_NOR;
          6'b000000, 6'b000100: OP = OP_SLL;
          6'b000010, 6'b000110, 6'b000111: OP = OP_SRL;
          6'b10101?:           OP = OP_SLT;
          default:             OP = OP_ADD;
        endcase
      end
      ALU_PASS: OP = OP_ADD;
      default:  OP = OP_ADD;
    endcase
  end

  always_comb begin
    hilo_rd = HILO_NONE;
    if (rtype && ex_en) begin
      if (funct == F_MFLO)      hilo_rd = HILO_LO;
      else if (funct == F_MFHI) hilo_rd = HILO_HI;
    end
  end

  ula_md_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .busy_i      (state_q == S_BUSY),
`ifdef ULA_MD_DIV_EN
    .is_div_i    (is_dvd),
`endif
    .is_signed_i (!funct[0]),
    .a_i         (rs_val),
    .b_i         (rt_val),
    .last_o      (last),
    .hi_res_o    (hi_res),
    .lo_res_o    (lo_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) state_q <= S_BUSY;
        S_BUSY: begin
          if (last) begin
            state_q <= S_DONE;
            hi_q    <= hi_res;
            lo_q    <= lo_res;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
